busmaster: RTL and testbench

BUSMASTER -- requirements
Module: busmaster

---
 rtl/busmaster_pkg.sv | 13 +
 rtl/busmaster_timer.sv | 30 +++
 rtl/busmaster.sv | 127 ++++++++++++
 tb/tb_busmaster.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/busmaster_pkg.sv
// busmaster shared types and constants.
// Bus widths, state encoding and default timeout.
package busmaster_pkg;
  localparam int DW          = 32;
  localparam int BEW         = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;
endpackage

// File: rtl/busmaster_timer.sv
// busmaster bus-phase timeout counter.
// Saturates at TIMEOUT-1; expired is high at that count.
module busmaster_timer
  import busmaster_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  assign expired = (r_cnt >= LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/busmaster.sv
// busmaster: single-outstanding core-to-bus master.
// Optional timeout response via `define BUSMASTER_TIMEOUT_EN.
module busmaster
  import busmaster_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic           req_we,
  input  logic [DW-1:0]  req_addr,
  input  logic [DW-1:0]  req_wdata,
  input  logic [BEW-1:0] req_be,
  output logic           req_ready,
  output logic           rsp_valid,
  output logic [DW-1:0]  rsp_rdata,
  output logic           rsp_err,
  output logic           en,
  output logic [DW-1:0]  addr,
  output logic [DW-1:0]  wdata,
  output logic           we,
  output logic [BEW-1:0] be,
  input  logic [DW-1:0]  rdata,
  input  logic           ack
);
  state_t r_state, w_state_nx;

  logic           r_we;
  logic [DW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic [BEW-1:0] r_be;
  logic [DW-1:0]  r_rdata;

  logic w_accept;
  logic w_bus;
  logic w_ack;
  logic w_expired;

  assign w_accept = (r_state == IDLE) && req;
  assign w_bus    = (r_state == BUS);
  assign w_ack    = w_bus && ack;

`ifdef BUSMASTER_TIMEOUT_EN
  logic r_err;

  busmaster_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_accept),
    .inc    (w_bus && !ack),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_ack) begin
      r_err <= 1'b0;
    end else if (w_bus && w_expired) begin
      r_err <= 1'b1;
    end
  end

  assign rsp_err = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_expired        = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (req) w_state_nx = BUS;
      BUS:     if (ack || w_expired) w_state_nx = RESP;
      RESP:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // Ack beats a simultaneous timeout; writes return zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_ack) begin
      r_rdata <= r_we ? '0 : rdata;
    end else if (w_bus && w_expired) begin
      r_rdata <= '0;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign en        = w_bus;
  assign we        = r_we;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign be        = r_be;
  assign rsp_rdata = r_rdata;
endmodule

// File: tb/tb_busmaster.sv
// Directed bench for busmaster with a transaction-level model.
// Timeout cases run only with BUSMASTER_TIMEOUT_EN defined.
module tb_busmaster;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [3:0]  be;
  logic [31:0] rdata = '0;
  logic        ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  busmaster #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .en(en), .addr(addr), .wdata(wdata), .we(we), .be(be),
    .rdata(rdata), .ack(ack)
  );

  // Transaction model: busy / responding flags and en-cycle count.
  bit          m_busy, m_resp, m_we;
  int          m_en_cycles;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_resp <= 0; m_we <= 0; m_en_cycles <= 0;
      m_addr <= '0; m_wdata <= '0; m_be <= '0;
      m_rdata <= '0; m_err <= 1'b0;
    end else if (m_resp) begin
      m_resp <= 0;
    end else if (m_busy) begin
      if (ack) begin
        m_rdata <= m_we ? 32'h0 : rdata;
        m_err <= 1'b0; m_busy <= 0; m_resp <= 1;
      end
`ifdef BUSMASTER_TIMEOUT_EN
      else if (m_en_cycles + 1 == TO) begin
        m_rdata <= 32'h0; m_err <= 1'b1; m_busy <= 0; m_resp <= 1;
      end
`endif
      else m_en_cycles <= m_en_cycles + 1;
    end else if (req) begin
      m_busy <= 1; m_en_cycles <= 0; m_we <= req_we;
      m_addr <= req_addr; m_wdata <= req_wdata; m_be <= req_be;
    end
  end

  logic [104:0] exp_v, act_v;
  assign exp_v = {!m_busy && !m_resp, m_busy, m_resp, m_err,
                  m_we, m_be, m_addr, m_wdata, m_rdata};
  assign act_v = {req_ready, en, rsp_valid, rsp_err,
                  we, be, addr, wdata, rsp_rdata};

  always @(negedge clk) begin
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model t=%0t got %h expected %h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; req_we = w; req_addr = a; req_wdata = d; req_be = b;
    step();
    req = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
  endtask

  int ncyc;
  int nval;
  string pat;

  initial begin
    step(); step();
    #2 rst_n = 1'b1;
    step();
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_en", {31'd0, en}, 32'd0);
    chk("reset_addr", addr, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);

    // Read, ack in first en cycle.
    issue(1'b0, 32'h0000_1004, 32'h0, 4'hF);
    chk("rd_en", {31'd0, en}, 32'd1);
    chk("rd_addr", addr, 32'h0000_1004);
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    ack = 1'b0; rdata = 32'h0;
    chk("rd_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_err", {31'd0, rsp_err}, 32'd0);
    chk("rd_resp_en", {31'd0, en}, 32'd0);
    step();
    chk("rd_hold", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_ready", {31'd0, req_ready}, 32'd1);

    // Write with 3 wait states.
    rdata = 32'h5555_AAAA;
    issue(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      chk("wr_en", {31'd0, en}, 32'd1);
      chk("wr_wdata", wdata, 32'h1234_5678);
      chk("wr_be", {28'd0, be}, 32'h3);
      if (i == 3) ack = 1'b1;
      step();
    end
    ack = 1'b0;
    chk("wr_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_err", {31'd0, rsp_err}, 32'd0);
    chk("wr_rdata", rsp_rdata, 32'd0);
    step();

`ifdef BUSMASTER_TIMEOUT_EN
    // No ack: timeout after TO en cycles.
    rdata = 32'hAAAA_5555;
    issue(1'b0, 32'h0000_3000, 32'h0, 4'hF);
    ncyc = 0;
    while (en && ncyc < 100) begin
      ncyc++;
      step();
    end
    chk("to_en_cycles", ncyc, 32'd16);
    chk("to_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rdata", rsp_rdata, 32'd0);
    step();
    chk("to_err_hold", {31'd0, rsp_err}, 32'd1);

    // Ack in the expiry cycle wins.
    rdata = 32'hCAFE_F00D;
    issue(1'b0, 32'h0000_3004, 32'h0, 4'hF);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) ack = 1'b1;
      step();
    end
    ack = 1'b0;
    chk("tie_valid", {31'd0, rsp_valid}, 32'd1);
    chk("tie_err", {31'd0, rsp_err}, 32'd0);
    chk("tie_rdata", rsp_rdata, 32'hCAFE_F00D);
    step();
`else
    // Without timeout the bus phase waits for ack indefinitely.
    rdata = 32'h0F0F_0F0F;
    issue(1'b0, 32'h0000_3000, 32'h0, 4'hF);
    for (int i = 0; i < 40; i++) step();
    chk("wait_en", {31'd0, en}, 32'd1);
    chk("wait_valid", {31'd0, rsp_valid}, 32'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("wait_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("wait_err", {31'd0, rsp_err}, 32'd0);
    chk("wait_rdata", rsp_rdata, 32'h0F0F_0F0F);
    step();
`endif

    // Reset during the third en cycle.
    issue(1'b1, 32'h0000_4000, 32'h7777_8888, 4'b1100);
    step(); step();
    chk("rst_pre_en", {31'd0, en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_en", {31'd0, en}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_addr", addr, 32'd0);
    nval = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      nval += int'(rsp_valid);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      nval += int'(rsp_valid);
    end
    chk("rst_no_valid", nval, 32'd0);
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

    // Back-to-back with req and ack held high.
    req = 1'b1; req_we = 1'b0; ack = 1'b1; rdata = 32'h1111_2222;
    pat = "";
    nval = 0;
    for (int i = 0; i < 9; i++) begin
      req_addr = 32'h100 + 32'(i);
      step();
      pat = {pat, en ? "1" : "0"};
      nval += int'(rsp_valid);
    end
    req = 1'b0; ack = 1'b0;
    n_tests++;
    if (pat != "100100100") begin
      n_fail++;
      $display("FAIL b2b_en_pattern: got %s expected 100100100", pat);
    end
    chk("b2b_rsp_count", nval, 32'd3);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
